// File: rtl/dvi_pkg.sv
// Shared definitions for the DVI transmitter: sequencer state encoding and
// the number of clk_x5 cycles per 10-bit TMDS symbol.
package dvi_pkg;

    typedef enum logic [1:0] {
        ST_OFF        = 2'd0,
        ST_LOCK_WAIT  = 2'd1,
        ST_CLK_WARMUP = 2'd2,
        ST_RUN        = 2'd3
    } dvi_state_e;

    localparam int DVI_SYMBOL_PHASES = 5;
    localparam int DVI_PHASE_W       = $clog2(DVI_SYMBOL_PHASES);

endpackage

// File: rtl/sync_1bit.sv
// Multi-flop synchroniser for a single level signal; output is 0 in reset.
module sync_1bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/dvi_tx_sequencer.sv
// Power-up / recovery sequencer: releases the pixel-clock lane after a filtered
// PLL lock, then the data lanes on a symbol boundary once the sink has warmed up.
module dvi_tx_sequencer
    import dvi_pkg::*;
#(
    parameter int SYNC_STAGES       = 2,
    parameter int LOCK_FILTER       = 16,
    parameter int CLK_WARMUP_CYCLES = 1024
) (
    input  logic clk_x5,
    input  logic rst_n_x5,
    input  logic en,
    input  logic pll_locked,
    output logic clk_lane_rst_n,
    output logic data_rst_n,
    output logic load_phase,
    output logic running,
    output logic lock_lost
);

    localparam int LOCK_W = $clog2(LOCK_FILTER + 1);
    localparam int WARM_W = $clog2(CLK_WARMUP_CYCLES + 1);

    localparam logic [LOCK_W-1:0]      LOCK_LAST  = LOCK_W'(LOCK_FILTER - 1);
    localparam logic [WARM_W-1:0]      WARM_LAST  = WARM_W'(CLK_WARMUP_CYCLES - 1);
    localparam logic [WARM_W-1:0]      WARM_MAX   = WARM_W'(CLK_WARMUP_CYCLES);
    localparam logic [DVI_PHASE_W-1:0] PHASE_LAST = DVI_PHASE_W'(DVI_SYMBOL_PHASES - 1);

    logic lk;

    dvi_state_e             state_q, state_d;
    logic [LOCK_W-1:0]      lock_cnt_q, lock_cnt_d;
    logic [WARM_W-1:0]      warm_cnt_q, warm_cnt_d;
    logic [DVI_PHASE_W-1:0] phase_q, phase_d;
    logic                   clk_lane_rst_n_q, clk_lane_rst_n_d;
    logic                   run_q, run_d;
    logic                   load_phase_q, load_phase_d;
    logic                   lock_lost_q, lock_lost_d;

    sync_1bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk_i   (clk_x5),
        .rst_n_i (rst_n_x5),
        .d_i     (pll_locked),
        .q_o     (lk)
    );

    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = '0;
        warm_cnt_d  = '0;
        lock_lost_d = lock_lost_q;

        case (state_q)
            ST_OFF: begin
                if (en) state_d = ST_LOCK_WAIT;
            end
            ST_LOCK_WAIT: begin
                if (lk) begin
                    if (lock_cnt_q >= LOCK_LAST) state_d = ST_CLK_WARMUP;
                    else                         lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end
            ST_CLK_WARMUP: begin
                if ((warm_cnt_q >= WARM_LAST) && (phase_q == PHASE_LAST)) begin
                    state_d = ST_RUN;
                end else if (warm_cnt_q == WARM_MAX) begin
                    warm_cnt_d = warm_cnt_q;
                end else begin
                    warm_cnt_d = warm_cnt_q + WARM_W'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
        endcase

        // Disable outranks lock loss, so a simultaneous drop leaves lock_lost clear.
        if (!lk && ((state_q == ST_CLK_WARMUP) || (state_q == ST_RUN))) begin
            state_d     = ST_LOCK_WAIT;
            lock_lost_d = 1'b1;
            warm_cnt_d  = '0;
        end
        if (!en) begin
            state_d     = ST_OFF;
            lock_lost_d = 1'b0;
            lock_cnt_d  = '0;
            warm_cnt_d  = '0;
        end

        clk_lane_rst_n_d = (state_d == ST_CLK_WARMUP) || (state_d == ST_RUN);
        run_d            = (state_d == ST_RUN);

        // Phase restarts at 0 in the first running cycle of the clock lane.
        if (clk_lane_rst_n_d && clk_lane_rst_n_q && (phase_q != PHASE_LAST)) begin
            phase_d = phase_q + DVI_PHASE_W'(1);
        end else begin
            phase_d = '0;
        end
        load_phase_d = clk_lane_rst_n_d && (phase_d == '0);
    end

    always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
        if (!rst_n_x5) begin
            state_q          <= ST_OFF;
            lock_cnt_q       <= '0;
            warm_cnt_q       <= '0;
            phase_q          <= '0;
            clk_lane_rst_n_q <= 1'b0;
            run_q            <= 1'b0;
            load_phase_q     <= 1'b0;
            lock_lost_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            lock_cnt_q       <= lock_cnt_d;
            warm_cnt_q       <= warm_cnt_d;
            phase_q          <= phase_d;
            clk_lane_rst_n_q <= clk_lane_rst_n_d;
            run_q            <= run_d;
            load_phase_q     <= load_phase_d;
            lock_lost_q      <= lock_lost_d;
        end
    end

    assign clk_lane_rst_n = clk_lane_rst_n_q;
    assign data_rst_n     = run_q;
    assign running        = run_q;
    assign load_phase     = load_phase_q;
    assign lock_lost      = lock_lost_q;

endmodule

// File: tb/tb_dvi_tx_sequencer.sv
// Bench for dvi_tx_sequencer: vector table for bring-up/loss/disable, directed
// corner sequences, and a randomized run against a release-time reference model.
module tb_dvi_tx_sequencer;

    localparam int SYNC = 2;
    localparam int LF   = 4;
    localparam int CWC  = 12;
    localparam int NPH  = 5;
    // Data release offset: smallest multiple of the symbol length >= warm-up.
    localparam int DREL = ((CWC + NPH - 1) / NPH) * NPH;

    logic clk_x5 = 1'b0;
    logic rst_n_x5 = 1'b0;
    logic en = 1'b0;
    logic pll_locked = 1'b0;
    logic clk_lane_rst_n, data_rst_n, load_phase, running, lock_lost;

    int checks = 0;
    int errors = 0;

    always #5 clk_x5 = ~clk_x5;

    dvi_tx_sequencer #(
        .SYNC_STAGES      (SYNC),
        .LOCK_FILTER      (LF),
        .CLK_WARMUP_CYCLES(CWC)
    ) dut (
        .clk_x5         (clk_x5),
        .rst_n_x5       (rst_n_x5),
        .en             (en),
        .pll_locked     (pll_locked),
        .clk_lane_rst_n (clk_lane_rst_n),
        .data_rst_n     (data_rst_n),
        .load_phase     (load_phase),
        .running        (running),
        .lock_lost      (lock_lost)
    );

    // Reference model: tracks the clock-lane release cycle and derives outputs
    // from the offset to it.
    int cyc;
    int rel;
    int streak;
    bit armed;
    bit lost;
    bit lkq[$];

    function automatic void model_reset();
        rel    = -1;
        streak = 0;
        armed  = 1'b0;
        lost   = 1'b0;
        cyc    = 0;
        lkq.delete();
        for (int i = 0; i < SYNC; i++) lkq.push_back(1'b0);
    endfunction

    function automatic void model_edge();
        bit lk_now;
        lk_now = lkq.pop_front();
        lkq.push_back(pll_locked);
        if (!en) begin
            armed = 1'b0; rel = -1; lost = 1'b0; streak = 0;
        end else if (rel >= 0 && !lk_now) begin
            rel = -1; lost = 1'b1; streak = 0;
        end else if (rel < 0) begin
            if (!armed) begin
                armed = 1'b1;
            end else if (lk_now) begin
                streak++;
                if (streak == LF) begin
                    rel = cyc + 1;
                    streak = 0;
                end
            end else begin
                streak = 0;
            end
        end
        cyc++;
    endfunction

    function automatic void chk(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0b want=%0b", name, cyc, act, exp);
        end
    endfunction

    function automatic void check_model();
        bit m_clk, m_dat, m_lp;
        int off;
        m_clk = (rel >= 0);
        off   = cyc - rel;
        m_dat = m_clk && (off >= DREL);
        m_lp  = m_clk && ((off % NPH) == 0);
        chk("model_clk_lane", clk_lane_rst_n, m_clk);
        chk("model_data_rst", data_rst_n, m_dat);
        chk("model_load_phase", load_phase, m_lp);
        chk("model_running", running, m_dat);
        chk("model_lock_lost", lock_lost, lost);
    endfunction

    task automatic tick();
        @(posedge clk_x5);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic run_to(int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        @(negedge clk_x5);
        rst_n_x5 = 1'b0;
        #1;
        chk("rst_clk_lane", clk_lane_rst_n, 1'b0);
        chk("rst_data_rst", data_rst_n, 1'b0);
        chk("rst_load_phase", load_phase, 1'b0);
        chk("rst_running", running, 1'b0);
        chk("rst_lock_lost", lock_lost, 1'b0);
        model_reset();
        @(posedge clk_x5);
        @(negedge clk_x5);
        rst_n_x5 = 1'b1;
    endtask

    // exp = {clk_lane_rst_n, data_rst_n, load_phase, running, lock_lost}
    typedef struct {
        int         cyc;
        logic       en;
        logic       pll;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{ 0, 1'b1, 1'b0, 5'b00000},
            '{10, 1'b1, 1'b1, 5'b00000},
            '{15, 1'b1, 1'b1, 5'b00000},
            '{16, 1'b1, 1'b1, 5'b10100},
            '{17, 1'b1, 1'b1, 5'b10000},
            '{21, 1'b1, 1'b1, 5'b10100},
            '{26, 1'b1, 1'b1, 5'b10100},
            '{30, 1'b1, 1'b1, 5'b10000},
            '{31, 1'b1, 1'b1, 5'b11110},
            '{32, 1'b1, 1'b1, 5'b11010},
            '{36, 1'b1, 1'b1, 5'b11110},
            '{40, 1'b1, 1'b0, 5'b11010},
            '{42, 1'b1, 1'b0, 5'b11010},
            '{43, 1'b1, 1'b0, 5'b00001},
            '{45, 1'b1, 1'b1, 5'b00001},
            '{50, 1'b1, 1'b1, 5'b00001},
            '{51, 1'b1, 1'b1, 5'b10101},
            '{65, 1'b1, 1'b1, 5'b10001},
            '{66, 1'b1, 1'b1, 5'b11111},
            '{70, 1'b0, 1'b1, 5'b11011},
            '{71, 1'b0, 1'b1, 5'b00000}
        };

        // Table: nominal bring-up, lock loss in RUN, re-lock, disable.
        do_reset();
        foreach (vecs[i]) begin
            run_to(vecs[i].cyc);
            en = vecs[i].en;
            pll_locked = vecs[i].pll;
            chk($sformatf("vec%0d_clk_lane", i), clk_lane_rst_n, vecs[i].exp[4]);
            chk($sformatf("vec%0d_data_rst", i), data_rst_n, vecs[i].exp[3]);
            chk($sformatf("vec%0d_load_phase", i), load_phase, vecs[i].exp[2]);
            chk($sformatf("vec%0d_running", i), running, vecs[i].exp[1]);
            chk($sformatf("vec%0d_lock_lost", i), lock_lost, vecs[i].exp[0]);
            $display("vec %0d cycle=%0d outputs=%b", i, cyc,
                     {clk_lane_rst_n, data_rst_n, load_phase, running, lock_lost});
        end

        // Lock glitch during the filter: release slips from 16 to 20.
        en = 1'b1; pll_locked = 1'b0;
        do_reset();
        run_to(10); pll_locked = 1'b1;
        run_to(13); pll_locked = 1'b0;
        run_to(14); pll_locked = 1'b1;
        run_to(19); chk("glitch_clk_before", clk_lane_rst_n, 1'b0);
        run_to(20); chk("glitch_clk_release", clk_lane_rst_n, 1'b1);
        chk("glitch_lock_lost", lock_lost, 1'b0);
        run_to(34); chk("glitch_data_before", data_rst_n, 1'b0);
        run_to(35); chk("glitch_data_release", data_rst_n, 1'b1);
        $display("seq glitch cycle=%0d clk_lane=%0b data=%0b", cyc, clk_lane_rst_n, data_rst_n);

        // Disable at R+5 during warm-up, then re-enable.
        pll_locked = 1'b0;
        do_reset();
        run_to(10); pll_locked = 1'b1;
        run_to(21); en = 1'b0;
        run_to(22);
        chk("dis_clk_lane", clk_lane_rst_n, 1'b0);
        chk("dis_load_phase", load_phase, 1'b0);
        chk("dis_lock_lost", lock_lost, 1'b0);
        run_to(25); en = 1'b1;
        run_to(29); chk("reen_clk_before", clk_lane_rst_n, 1'b0);
        run_to(30); chk("reen_clk_release", clk_lane_rst_n, 1'b1);
        run_to(44); chk("reen_data_before", data_rst_n, 1'b0);
        run_to(45); chk("reen_data_release", data_rst_n, 1'b1);
        chk("reen_load_aligned", load_phase, 1'b1);
        $display("seq disable cycle=%0d running=%0b", cyc, running);

        // Async reset mid-RUN, restart from OFF with lock already present.
        run_to(50);
        chk("arst_pre_running", running, 1'b1);
        do_reset();
        run_to(5); chk("arst_clk_before", clk_lane_rst_n, 1'b0);
        run_to(6); chk("arst_clk_release", clk_lane_rst_n, 1'b1);
        $display("seq async_reset cycle=%0d clk_lane=%0b", cyc, clk_lane_rst_n);

        // Disable and lock loss in the same cycle: disable wins.
        run_to(30); chk("simul_pre_running", running, 1'b1);
        pll_locked = 1'b0;
        run_to(32); en = 1'b0;
        run_to(33);
        chk("simul_lock_lost", lock_lost, 1'b0);
        chk("simul_running", running, 1'b0);
        en = 1'b1; pll_locked = 1'b1;
        run_to(60);
        $display("seq simultaneous cycle=%0d lock_lost=%0b", cyc, lock_lost);

        // Randomized run against the reference model.
        for (int n = 0; n < 5000; n++) begin
            if ($urandom_range(0, 149) == 0) en = ~en;
            if ($urandom_range(0, 29) == 0) pll_locked = ~pll_locked;
            if ($urandom_range(0, 799) == 0) do_reset();
            tick();
        end
        $display("random done cycle=%0d", cyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dvi_tx_sequencer.md
# dvi_tx_sequencer

Power-up and recovery sequencer for the DVI transmitter, in the `clk_x5` (5× pixel, half-rate bit) domain. It gates the pixel-clock lane and the three TMDS data serialisers from PLL lock. It releases the clock lane first, lets the sink lock, then releases the data lanes aligned to the clock lane's ring phase. It also generates the 1-in-5 `load_phase` strobe the data serialisers use to take a new 10-bit symbol.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flops in the `pll_locked` synchroniser; minimum 2.
- `LOCK_FILTER`, default 16: consecutive synchronised-locked cycles required before leaving LOCK_WAIT; minimum 1.
- `CLK_WARMUP_CYCLES`, default 1024: minimum `clk_x5` cycles the clock lane runs before the data lanes are released; minimum 1.

Ports:
- `clk_x5`  in  1  half-rate bit clock.
- `rst_n_x5`  in  1  reset: reset `rst_n_x5`, asynchronous, active-low; clock `clk_x5`.
- `en`  in  1  transmitter enable, `clk_x5` domain.
- `pll_locked`  in  1  PLL lock, asynchronous; synchronised internally.
- `clk_lane_rst_n`  out  1  active-low reset to the pixel-clock lane driver.
- `data_rst_n`  out  1  active-low reset to the data serialisers.
- `load_phase`  out  1  symbol-load strobe, one cycle in five.
- `running`  out  1  high in RUN.
- `lock_lost`  out  1  sticky flag: lock dropped during CLK_WARMUP or RUN.

## Operation
- All outputs are registered. During and after reset every output is 0, state is OFF, and `phase` is 0.
- OFF: both lane resets asserted. If `en`=1, go to LOCK_WAIT.
- LOCK_WAIT: `lock_cnt` increments on each cycle with synchronised lock (`lk`) = 1 and clears to 0 on `lk`=0. When `lock_cnt` reaches `LOCK_FILTER`-1 with `lk`=1, go to CLK_WARMUP.
- CLK_WARMUP: `clk_lane_rst_n`=1.
  - `warm_cnt` counts from 0, starting in the first cycle with `clk_lane_rst_n`=1, and saturates at `CLK_WARMUP_CYCLES`.
  - Go to RUN when `warm_cnt` ≥ `CLK_WARMUP_CYCLES`-1 and `phase`=4.
- RUN: both resets deasserted; `running`=1.
- Priority, highest first:
  1. `en`=0 in any state: go to OFF next cycle and clear `lock_lost`.
  2. `lk`=0 in CLK_WARMUP or RUN: go to LOCK_WAIT next cycle, set `lock_lost`, reassert both resets.
- `phase` is a mod-5 counter (0..4). It is held at 0 while `clk_lane_rst_n`=0 and increments every cycle while it is 1. Cycle k after clock-lane release therefore has `phase` = k mod 5.
- `load_phase` = (`phase`=0) AND `clk_lane_rst_n`. It is asserted from the clock lane's first running cycle, including during CLK_WARMUP.
- `en` deasserting mid-sequence aborts cleanly: no partial release survives, and the next enable restarts from LOCK_WAIT with full filtering and warm-up.

## Timing
- Latency from `pll_locked` to `lk` is `SYNC_STAGES` cycles.
- `clk_lane_rst_n` rises in the cycle after the state changes LOCK_WAIT→CLK_WARMUP. Call that cycle R.
- `data_rst_n` and `running` first read 1 in the smallest cycle D > R such that D-R ≥ `CLK_WARMUP_CYCLES` and (D-R) mod 5 = 0.
  - Consequence: `data_rst_n` always rises coincident with a `load_phase` pulse.
- Lock loss: `lk` reads 0 in cycle t, so both resets and `running` read 0 in t+1, and `lock_lost`=1 in t+1.
- `en`=0 in cycle t: OFF in t+1, and all outputs read 0 in t+1.
- `lock_cnt` is $clog2(`LOCK_FILTER`+1) bits wide and `warm_cnt` is $clog2(`CLK_WARMUP_CYCLES`+1) bits wide. Neither may wrap.

## Structure
- Shared package `dvi_pkg`: state encoding (OFF=0, LOCK_WAIT=1, CLK_WARMUP=2, RUN=3, 2 bits) and `DVI_SYMBOL_PHASES`=5.
- Sub-module `sync_1bit` (parameter `SYNC_STAGES`, async reset to 0) synchronises `pll_locked`.
- Everything else is one FSM process plus the `phase`, `lock_cnt` and `warm_cnt` counters.

## Test plan
Parameters for all scenarios: `LOCK_FILTER`=4, `CLK_WARMUP_CYCLES`=12, `SYNC_STAGES`=2.
- Nominal bring-up:
  - Stimulus: `en`=1, `pll_locked` rises at cycle 10.
  - Required: `clk_lane_rst_n` rises at cycle 16 (R), `load_phase` at 16, 21, 26, 31; `data_rst_n` and `running` rise at 31, which is the first cycle ≥ R+12 with `phase`=0.
- Lock glitch during filter:
  - Stimulus: `pll_locked` high 3 cycles, low 1 cycle, then high.
  - Required: `lock_cnt` restarts from 0; `clk_lane_rst_n` is delayed accordingly; `lock_lost` stays 0.
- Lock loss in RUN:
  - Stimulus: drop `pll_locked`.
  - Required: resets and `running` go low 3 cycles after the drop; `lock_lost`=1; re-lock repeats the full filter and warm-up; `lock_lost` stays 1.
- Disable mid-warm-up:
  - Stimulus: `en`=0 at R+5.
  - Required: all outputs 0 at R+6; `lock_lost` cleared; re-enable gives a nominal sequence.
- Async reset mid-RUN:
  - Stimulus: pulse `rst_n_x5` low.
  - Required: all outputs 0 immediately; OFF state after release.
- Simultaneous events:
  - Stimulus: `en`=0 and lock loss in the same cycle.
  - Required: state OFF and `lock_lost`=0.
